lcd_cmd_sequencer: RTL and testbench
====================================

// Module: lcd_cmd_sequencer
// PURPOSE
//  Upstream command feeder for the LCD image-control stage. A host pushes 4-bit commands into an
//  internal FIFO. The block issues them one at a time on cmd/cmd_valid. Each issue waits on the
//  consumer's busy/done handshake. Issuing stops permanently after the write command (0) is
//  acknowledged by done.
// PARAMETERS
//  DEPTH    16   FIFO entries (power of 2, >=2)
//  TIMEOUT  255  max cycles to wait for busy to rise after an issue (8-bit counter)
// PORTS
//  clk          in   1  clock, all logic on rising edge
//  reset        in   1  asynchronous, active-high reset
//  push_valid   in   1  host offers push_cmd this cycle
//  push_cmd     in   4  command code 0..11 (0 = write-out, 1..11 = shift/max/min/avg/rot/mirror)
//  push_ready   out  1  FIFO can accept (= !full, combinational from count)
//  cmd          out  4  command to consumer, registered
//  cmd_valid    out  1  one-cycle issue strobe, registered
//  busy         in   1  consumer busy
//  done         in   1  consumer finished write-out
//  fifo_count   out  $clog2(DEPTH)+1  entries held
//  issued_cnt   out  8  commands issued since reset, wraps 255->0
//  seq_done     out  1  high in HALT
//  err_illegal  out  1  one-cycle pulse when a push with code 12..15 is accepted-and-dropped
//  err_timeout  out  1  sticky until reset: busy never rose within TIMEOUT cycles
// BEHAVIOUR
//  Reset: state READY; FIFO empty; cmd=0, cmd_valid=0, issued_cnt=0, seq_done=0, err_*=0.
//   push_ready=1 after reset.
//  FIFO: a push is accepted when push_valid & push_ready.
//   - Codes 12..15 are consumed, not stored; err_illegal pulses next cycle.
//   - Simultaneous push+pop: count unchanged.
//   - While full, push_ready=0 even if a pop occurs in the same cycle.
//   - Pointers wrap modulo DEPTH.
//  States:
//   READY     : if fifo nonempty & busy==0: pop head, register cmd=head, cmd_valid=1,
//               issued_cnt+=1, tmo=0; go WAIT_HI. Otherwise hold, cmd_valid=0.
//   WAIT_HI   : cmd_valid=0. If busy==1, go WAIT_LO.
//               Else tmo+=1; when tmo==TIMEOUT, set err_timeout and go READY (command dropped).
//   WAIT_LO   : if issued code was 0: wait done==1 -> HALT.
//               Else wait busy==0 -> READY. done seen with a nonzero code is ignored.
//   HALT      : seq_done=1; no further issues; FIFO still accepts pushes until full; exit only
//               by reset.
//  Latency: push at cycle N into an empty FIFO with busy==0 and state READY -> cmd_valid at N+2
//   (count updates at N+1; issue is registered at N+2).
//  Minimum spacing between two issues: 1 + cycles of busy high + 1.
//  busy is sampled only in READY/WAIT_HI/WAIT_LO. busy going high while READY with the FIFO empty
//   is harmless: the block simply stays in READY.
//  Reset mid-operation: all state, FIFO contents and counters are cleared immediately.
//   cmd_valid drops asynchronously.
// TESTING
//  1 reset, busy=0, push 3,4,5 back-to-back; consumer raises busy 1 cycle after each cmd_valid
//    for 2 cycles -> cmd_valid pulses carry 3,4,5 in order, each exactly 1 cycle, issued_cnt=3.
//  2 push 1,0,2; busy handshake as in 1, done=1 two cycles after the issue of 0 ->
//    seq_done=1; cmd 2 is never issued; fifo_count=1.
//  3 hold busy=1 and push DEPTH+2 cmds -> push_ready=0 at count=16; last 2 pushes not accepted;
//    release busy -> all 16 issued in order.
//  4 push 13 then 6 -> err_illegal pulses once; only 6 is issued; fifo_count never exceeds 1.
//  5 issue with busy held 0 forever -> err_timeout=1 after 255 WAIT_HI cycles; state returns to
//    READY; the next cmd still issues.
//  6 assert reset while in WAIT_LO with 5 entries queued -> cmd_valid=0, fifo_count=0,
//    issued_cnt=0, err_timeout=0 immediately.

Source files
------------

// File: rtl/lcd_cmd_sequencer.sv
// rtl/lcd_cmd_sequencer.sv - command FIFO and issue sequencer feeding the LCD image-control stage
// Commands are issued one at a time against the consumer busy/done handshake; write-out (0) halts it.

module lcd_cmd_sequencer #(
   parameter int DEPTH   = 16,
   parameter int TIMEOUT = 255
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_valid,
   input  logic [3:0]               push_cmd,
   output logic                     push_ready,
   output logic [3:0]               cmd,
   output logic                     cmd_valid,
   input  logic                     busy,
   input  logic                     done,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic [7:0]               issued_cnt,
   output logic                     seq_done,
   output logic                     err_illegal,
   output logic                     err_timeout
);

   localparam int              AW        = $clog2(DEPTH);
   localparam logic [AW:0]     FULL_CNT  = (AW+1)'(DEPTH);
   localparam logic [AW:0]     ONE_CNT   = (AW+1)'(1);
   localparam logic [AW-1:0]   ONE_PTR   = AW'(1);
   localparam logic [7:0]      TMO_LIMIT = 8'(TIMEOUT);

   typedef enum logic [1:0] {READY, WAIT_HI, WAIT_LO, HALT} state_t;

   state_t          state_q, state_d;
   logic [3:0]      mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     count_q, count_d;
   logic [3:0]      cmd_q, cmd_d;
   logic            cmd_valid_q, cmd_valid_d;
   logic [7:0]      issued_q, issued_d;
   logic [7:0]      tmo_q, tmo_d;
   logic [7:0]      tmo_inc;
   logic            seq_done_q, seq_done_d;
   logic            err_ill_q, err_ill_d;
   logic            err_tmo_q, err_tmo_d;
   logic            push_acc;
   logic            push_legal;
   logic            pop;

   assign push_ready  = (count_q != FULL_CNT);
   assign cmd         = cmd_q;
   assign cmd_valid   = cmd_valid_q;
   assign fifo_count  = count_q;
   assign issued_cnt  = issued_q;
   assign seq_done    = seq_done_q;
   assign err_illegal = err_ill_q;
   assign err_timeout = err_tmo_q;

   always_comb begin
      push_acc    = push_valid & push_ready;
      push_legal  = push_acc & (push_cmd < 4'd12);
      pop         = 1'b0;
      state_d     = state_q;
      cmd_d       = cmd_q;
      cmd_valid_d = 1'b0;
      issued_d    = issued_q;
      tmo_inc     = tmo_q + 8'd1;
      tmo_d       = tmo_q;
      err_tmo_d   = err_tmo_q;
      err_ill_d   = push_acc & ~push_legal;

      unique case (state_q)
         READY: begin
            if ((count_q != '0) && !busy) begin
               pop         = 1'b1;
               cmd_d       = mem_q[rd_ptr_q];
               cmd_valid_d = 1'b1;
               issued_d    = issued_q + 8'd1;
               tmo_d       = 8'd0;
               state_d     = WAIT_HI;
            end
         end
         WAIT_HI: begin
            if (busy) begin
               state_d = WAIT_LO;
            end else begin
               tmo_d = tmo_inc;
               // Consumer never acknowledged: the command is dropped, not retried.
               if (tmo_inc == TMO_LIMIT) begin
                  err_tmo_d = 1'b1;
                  state_d   = READY;
               end
            end
         end
         WAIT_LO: begin
            if (cmd_q == 4'd0) begin
               if (done) state_d = HALT;
            end else if (!busy) begin
               state_d = READY;
            end
         end
         default: state_d = HALT;
      endcase

      seq_done_d = (state_d == HALT);
      wr_ptr_d   = push_legal ? (wr_ptr_q + ONE_PTR) : wr_ptr_q;
      rd_ptr_d   = pop ? (rd_ptr_q + ONE_PTR) : rd_ptr_q;

      unique case ({push_legal, pop})
         2'b10:   count_d = count_q + ONE_CNT;
         2'b01:   count_d = count_q - ONE_CNT;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= READY;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         cmd_q       <= 4'd0;
         cmd_valid_q <= 1'b0;
         issued_q    <= 8'd0;
         tmo_q       <= 8'd0;
         seq_done_q  <= 1'b0;
         err_ill_q   <= 1'b0;
         err_tmo_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= 4'd0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         cmd_q       <= cmd_d;
         cmd_valid_q <= cmd_valid_d;
         issued_q    <= issued_d;
         tmo_q       <= tmo_d;
         seq_done_q  <= seq_done_d;
         err_ill_q   <= err_ill_d;
         err_tmo_q   <= err_tmo_d;
         if (push_legal) mem_q[wr_ptr_q] <= push_cmd;
      end
   end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// tb/tb_lcd_cmd_sequencer.sv - randomized and directed bench for lcd_cmd_sequencer
// A queue-based reference model predicts every output each cycle.

module tb_lcd_cmd_sequencer;

   localparam int DEPTH   = 16;
   localparam int TIMEOUT = 255;
   localparam int CW      = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          push_valid;
   logic [3:0]    push_cmd;
   logic          push_ready;
   logic [3:0]    cmd;
   logic          cmd_valid;
   logic          busy;
   logic          done;
   logic [CW-1:0] fifo_count;
   logic [7:0]    issued_cnt;
   logic          seq_done;
   logic          err_illegal;
   logic          err_timeout;

   lcd_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .reset       (reset),
      .push_valid  (push_valid),
      .push_cmd    (push_cmd),
      .push_ready  (push_ready),
      .cmd         (cmd),
      .cmd_valid   (cmd_valid),
      .busy        (busy),
      .done        (done),
      .fifo_count  (fifo_count),
      .issued_cnt  (issued_cnt),
      .seq_done    (seq_done),
      .err_illegal (err_illegal),
      .err_timeout (err_timeout)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference model: phase 0 idle, 1 awaiting busy, 2 awaiting release/done, 3 halted.
   int mq[$];
   int m_ph, m_tmo, m_cmd, m_valid, m_issued, m_seqd, m_ill, m_terr;

   // Consumer stimulus
   int c_D = 1, c_L = 2;
   bit c_rand = 0, noise = 0;
   int c_start, c_len, c_act, c_is0;

   // Observations
   int cyc = 0;
   int obs[$];
   int issue_cyc[$];
   int ill_seen, max_cnt, tmo_rise;

   task automatic clear_obs();
      obs.delete();
      issue_cyc.delete();
      ill_seen = 0;
      max_cnt  = 0;
      tmo_rise = -1;
   endtask

   task automatic model_reset();
      mq.delete();
      m_ph = 0; m_tmo = 0; m_cmd = 0; m_valid = 0; m_issued = 0;
      m_seqd = 0; m_ill = 0; m_terr = 0;
      c_act = 0; c_start = 0; c_len = 0; c_is0 = 0;
   endtask

   task automatic check_outputs();
      check_val("push_ready",  push_ready,  (mq.size() < DEPTH) ? 1 : 0);
      check_val("fifo_count",  fifo_count,  mq.size());
      check_val("cmd_valid",   cmd_valid,   m_valid);
      check_val("cmd",         cmd,         m_cmd);
      check_val("issued_cnt",  issued_cnt,  m_issued);
      check_val("seq_done",    seq_done,    m_seqd);
      check_val("err_illegal", err_illegal, m_ill);
      check_val("err_timeout", err_timeout, m_terr);
      if (cmd_valid === 1'b1) begin
         obs.push_back(int'(cmd));
         issue_cyc.push_back(cyc);
      end
      if (err_illegal === 1'b1) ill_seen++;
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
      if (err_timeout === 1'b1 && tmo_rise < 0) tmo_rise = cyc;
   endtask

   // Called just after a falling edge; returns just after the next falling edge.
   // bmode: 0 consumer model, 1 busy forced high, 2 busy/done forced low.
   task automatic step(input bit pv, input int pc, input int bmode);
      bit b, d, acc;
      int nph, nvalid;
      check_outputs();
      b = 0; d = 0;
      if (m_valid != 0) begin
         c_act   = 1;
         c_start = c_rand ? int'($urandom_range(0, 2)) : c_D;
         c_len   = c_rand ? int'($urandom_range(1, 4)) : c_L;
         c_is0   = (m_cmd == 0);
      end
      if (c_act != 0) begin
         if (c_start > 0) c_start--;
         else if (c_len > 0) begin b = 1; c_len--; end
         else begin d = (c_is0 != 0); c_act = 0; end
      end else if (noise) begin
         b = ($urandom_range(0, 9) == 0);
         d = ($urandom_range(0, 9) == 0);
      end
      if (bmode == 1) begin b = 1; d = 0; c_act = 0; end
      else if (bmode == 2) begin b = 0; d = 0; c_act = 0; end

      push_valid = pv;
      push_cmd   = 4'(pc);
      busy       = b;
      done       = d;

      acc    = pv && (mq.size() < DEPTH);
      nph    = m_ph;
      nvalid = 0;
      case (m_ph)
         0: if (mq.size() > 0 && !b) begin
               m_cmd    = mq.pop_front();
               nvalid   = 1;
               m_issued = (m_issued + 1) % 256;
               m_tmo    = 0;
               nph      = 1;
            end
         1: if (b) nph = 2;
            else begin
               m_tmo++;
               if (m_tmo == TIMEOUT) begin m_terr = 1; nph = 0; end
            end
         2: if (m_cmd == 0) begin if (d) nph = 3; end
            else if (!b) nph = 0;
         default: nph = 3;
      endcase
      if (acc && pc < 12) mq.push_back(pc);
      m_ill   = (acc && pc >= 12) ? 1 : 0;
      m_valid = nvalid;
      m_ph    = nph;
      m_seqd  = (nph == 3) ? 1 : 0;
      cyc++;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1; push_valid = 0; push_cmd = 0; busy = 0; done = 0;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      int ok;
      reset = 1; push_valid = 0; push_cmd = 0; busy = 0; done = 0;
      model_reset();
      clear_obs();
      @(negedge clk);
      check_val("rst_push_ready", push_ready, 1);
      check_val("rst_cmd_valid",  cmd_valid,  0);
      check_val("rst_fifo_count", fifo_count, 0);
      check_val("rst_issued",     issued_cnt, 0);
      @(negedge clk);
      reset = 0;

      // Three back-to-back pushes, busy for 2 cycles one cycle after each issue.
      clear_obs(); c_D = 1; c_L = 2;
      t0 = cyc;
      step(1, 3, 0); step(1, 4, 0); step(1, 5, 0);
      repeat (20) step(0, 0, 0);
      check_val("t1_issued_cnt", issued_cnt, 3);
      check_val("t1_n_issues", obs.size(), 3);
      for (int i = 0; i < obs.size() && i < 3; i++) check_val("t1_order", obs[i], 3 + i);
      if (issue_cyc.size() > 0) check_val("t1_latency", issue_cyc[0] - t0, 2);

      // Write-out halts the sequencer; the trailing command stays queued.
      do_reset(); clear_obs(); c_D = 1; c_L = 1;
      step(1, 1, 0); step(1, 0, 0); step(1, 2, 0);
      repeat (20) step(0, 0, 0);
      check_val("t2_seq_done", seq_done, 1);
      check_val("t2_fifo_count", fifo_count, 1);
      check_val("t2_n_issues", obs.size(), 2);
      if (obs.size() >= 2) begin
         check_val("t2_first", obs[0], 1);
         check_val("t2_second", obs[1], 0);
      end

      // Fill to full with busy held, then drain in order.
      do_reset(); clear_obs(); c_D = 1; c_L = 2;
      for (int i = 0; i < DEPTH + 2; i++) step(1, 1 + (i % 11), 1);
      check_val("t3_full_count", fifo_count, DEPTH);
      check_val("t3_full_ready", push_ready, 0);
      repeat (150) step(0, 0, 0);
      check_val("t3_n_issues", obs.size(), DEPTH);
      for (int i = 0; i < obs.size() && i < DEPTH; i++) check_val("t3_order", obs[i], 1 + (i % 11));

      // Illegal code is dropped with a single pulse.
      do_reset(); clear_obs(); c_D = 1; c_L = 2;
      step(1, 13, 0); step(1, 6, 0);
      repeat (10) step(0, 0, 0);
      check_val("t4_ill_pulses", ill_seen, 1);
      check_val("t4_n_issues", obs.size(), 1);
      if (obs.size() > 0) check_val("t4_cmd", obs[0], 6);
      check_val("t4_max_count", (max_cnt <= 1) ? 1 : 0, 1);

      // Consumer never raises busy: timeout, command dropped, next one still issues.
      do_reset(); clear_obs();
      step(1, 7, 2); step(1, 8, 2);
      repeat (270) step(0, 0, 2);
      check_val("t5_err_timeout", err_timeout, 1);
      check_val("t5_n_issues", obs.size(), 2);
      if (issue_cyc.size() > 0 && tmo_rise >= 0) check_val("t5_tmo_latency", tmo_rise - issue_cyc[0], TIMEOUT);
      else check_val("t5_tmo_seen", (tmo_rise >= 0) ? 1 : 0, 1);
      if (obs.size() >= 2) check_val("t5_second", obs[1], 8);
      repeat (260) step(0, 0, 2);

      // Reset while waiting on busy release with five entries queued.
      c_D = 0; c_L = 40;
      for (int i = 0; i < 6; i++) step(1, 9, 0);
      for (int i = 0; i < 50; i++) begin
         if (m_ph == 2 && mq.size() == 5) break;
         step(0, 0, 0);
      end
      check_val("t6_fifo_before", fifo_count, 5);
      check_val("t6_terr_before", err_timeout, 1);
      reset = 1;
      #1;
      check_val("t6_cmd_valid",   cmd_valid,   0);
      check_val("t6_fifo_count",  fifo_count,  0);
      check_val("t6_issued_cnt",  issued_cnt,  0);
      check_val("t6_err_timeout", err_timeout, 0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset = 0;

      // Randomized traffic with a jittery consumer, then a final write-out.
      clear_obs(); c_rand = 1; noise = 1;
      repeat (1500) step($urandom_range(0, 9) < 6, int'($urandom_range(1, 15)), 0);
      ok = 0;
      for (int i = 0; i < 400 && ok == 0; i++) begin
         if (mq.size() < DEPTH) begin step(1, 0, 0); ok = 1; end
         else step(0, 0, 0);
      end
      for (int i = 0; i < 1000 && m_ph != 3; i++) step(0, 0, 0);
      step(0, 0, 0);
      check_val("rnd_seq_done", seq_done, 1);
      repeat (20) step(1, int'($urandom_range(1, 11)), 0);
      check_val("rnd_halt_full", fifo_count, DEPTH);
      check_val("rnd_halt_ready", push_ready, 0);
      step(0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
